mem_access_ctrl: RTL and testbench

- Sequences data-memory accesses for the memory stage of the 5-stage pipeline.
- Watches the XM pipeline-register outputs. For each load or store it:
  - issues a request to a multi-cycle data memory that can stall,
  - holds the front of the pipeline until the memory completes,
  - presents the captured read data to the MW stage.
- Also flags unaligned accesses and memory timeouts, and keeps a saturating count of stall cycles for performance checks.

---
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_access_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the memory-stage access controller and a multi-cycle memory.
//   mem_en      : request strobe, held while the memory reports stall
//   mem_wr      : 1 = write, 0 = read; valid with mem_en
//   mem_addr    : request byte address
//   mem_dataIn  : store data
//   mem_stall   : memory cannot accept a request this cycle
//   mem_done    : memory completed the outstanding request
//   mem_dataOut : read data, valid with mem_done
interface mem_access_ctrl_if;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_dataIn;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_dataOut;

  modport master (
    output mem_en,
    output mem_wr,
    output mem_addr,
    output mem_dataIn,
    input  mem_stall,
    input  mem_done,
    input  mem_dataOut
  );

  modport slave (
    input  mem_en,
    input  mem_wr,
    input  mem_addr,
    input  mem_dataIn,
    output mem_stall,
    output mem_done,
    output mem_dataOut
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer for the 5-stage pipeline.
// Watches the XM pipeline register. For each aligned load/store it issues a request to a
// stallable multi-cycle data memory, holds the front of the pipeline until the memory
// completes (or times out) and then hands the load data to the MW stage for one cycle.
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   XM_memRead     : load in memory stage
//   XM_memWrite    : store in memory stage (wins if both are set)
//   XM_aluOut      : byte address
//   XM_writeData   : store data
//   mem            : memory bus (master side)
//   pipe_stall     : holds FD/DX/XM and bubbles MW
//   rd_valid       : rd_data valid for MW (one cycle)
//   rd_data        : captured load data (16'hFFFF after a timeout)
//   err_unaligned  : odd address on an access, no request issued
//   err_timeout    : memory timed out (one cycle)
//   stall_cnt      : saturating count of pipe_stall cycles
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16  // legal range 2..255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     XM_memRead,
  input  logic                     XM_memWrite,
  input  logic [15:0]              XM_aluOut,
  input  logic [15:0]              XM_writeData,
  mem_access_ctrl_if.master        mem,
  output logic                     pipe_stall,
  output logic                     rd_valid,
  output logic [15:0]              rd_data,
  output logic                     err_unaligned,
  output logic                     err_timeout,
  output logic [15:0]              stall_cnt
);

  // Counter value in the WAIT cycle whose increment would reach TIMEOUT_CYC-1.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic acc;
  logic idle_accept;

  always_comb begin
    acc         = XM_memRead | XM_memWrite;
    idle_accept = (state_q == StIdle) && acc && !XM_aluOut[0];

    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rd_data_d  = rd_data_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (idle_accept) begin
          addr_d  = XM_aluOut;
          wdata_d = XM_writeData;
          wr_d    = XM_memWrite;
          state_d = StReq;
        end
      end
      StReq: begin
        // Request stays pending while the memory stalls.
        if (!mem.mem_stall) begin
          wait_cnt_d = 8'd0;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (mem.mem_done) begin
          if (!wr_q) rd_data_d = mem.mem_dataOut;
          state_d = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WaitLast) begin
            rd_data_d = 16'hFFFF;
            timeout_d = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StResp: begin
        // XM advances this cycle, so acc is not looked at here.
        timeout_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    pipe_stall  = idle_accept || (state_q == StReq) || (state_q == StWait);
    stall_cnt_d = (pipe_stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

    rd_valid      = (state_q == StResp) && !wr_q;
    err_timeout   = (state_q == StResp) && timeout_q;
    err_unaligned = (state_q == StIdle) && acc && XM_aluOut[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= 16'd0;
      wdata_q     <= 16'd0;
      wr_q        <= 1'b0;
      rd_data_q   <= 16'd0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rd_data_q   <= rd_data_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem.mem_en     = (state_q == StReq);
  assign mem.mem_wr     = wr_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_dataIn = wdata_q;
  assign rd_data        = rd_data_q;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: inputs are applied on the falling edge, outputs are
// checked 1 ns later, and the DUT registers update on the following rising edge.
module tb_mem_access_ctrl;
  logic        clk;
  logic        rst;
  logic        XM_memRead;
  logic        XM_memWrite;
  logic [15:0] XM_aluOut;
  logic [15:0] XM_writeData;
  logic        pipe_stall;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        err_unaligned;
  logic        err_timeout;
  logic [15:0] stall_cnt;

  mem_access_ctrl_if mif ();

  mem_access_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .XM_memRead    (XM_memRead),
    .XM_memWrite   (XM_memWrite),
    .XM_aluOut     (XM_aluOut),
    .XM_writeData  (XM_writeData),
    .mem           (mif.master),
    .pipe_stall    (pipe_stall),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .err_unaligned (err_unaligned),
    .err_timeout   (err_timeout),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int en_n, stall_n, rdv_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: apply inputs on the falling edge, let comb logic settle, tally strobes.
  task automatic drive(input logic rst_v, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic stall, input logic done, input logic [15:0] dout);
    @(negedge clk);
    rst              = rst_v;
    XM_memRead       = rd;
    XM_memWrite      = wr;
    XM_aluOut        = addr;
    XM_writeData     = wdata;
    mif.mem_stall    = stall;
    mif.mem_done     = done;
    mif.mem_dataOut  = dout;
    #1;
    en_n    += 32'(mif.mem_en);
    stall_n += 32'(pipe_stall);
    rdv_n   += 32'(rd_valid);
  endtask

  task automatic idle_cyc();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic clr_tally();
    en_n    = 0;
    stall_n = 0;
    rdv_n   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_tally();
    // Reset
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    idle_cyc();
    check_eq("rst_mem_en",     32'(mif.mem_en), 0);
    check_eq("rst_pipe_stall", 32'(pipe_stall), 0);
    check_eq("rst_mem_addr",   32'(mif.mem_addr), 0);
    check_eq("rst_rd_data",    32'(rd_data), 0);
    check_eq("rst_stall_cnt",  32'(stall_cnt), 0);

    // Aligned load, minimum latency
    clr_tally();
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("ld_c0_stall", 32'(pipe_stall), 1);
    check_eq("ld_c0_en",    32'(mif.mem_en), 0);
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("ld_c1_en",    32'(mif.mem_en), 1);
    check_eq("ld_c1_wr",    32'(mif.mem_wr), 0);
    check_eq("ld_c1_addr",  32'(mif.mem_addr), 32'h0010);
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b1, 16'hBEEF);
    check_eq("ld_c2_en",    32'(mif.mem_en), 0);
    check_eq("ld_c2_stall", 32'(pipe_stall), 1);
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("ld_resp_valid", 32'(rd_valid), 1);
    check_eq("ld_resp_data",  32'(rd_data), 32'hBEEF);
    check_eq("ld_resp_stall", 32'(pipe_stall), 0);
    idle_cyc();
    check_eq("ld_en_cycles",    en_n, 1);
    check_eq("ld_stall_cycles", stall_n, 3);
    check_eq("ld_stall_cnt",    32'(stall_cnt), 3);

    // Store with 2 memory-stall cycles and done on the 4th WAIT cycle
    clr_tally();
    drive(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'h0);
    check_eq("st_req_wr",    32'(mif.mem_wr), 1);
    check_eq("st_req_wdata", 32'(mif.mem_dataIn), 32'h1234);
    drive(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'h0);
    check_eq("st_req_en3",   32'(mif.mem_en), 1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b1, 16'hCAFE);
    drive(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'h0);
    check_eq("st_resp_valid", 32'(rd_valid), 0);
    check_eq("st_resp_stall", 32'(pipe_stall), 0);
    check_eq("st_rd_data",    32'(rd_data), 32'hBEEF);
    idle_cyc();
    check_eq("st_en_cycles",    en_n, 3);
    check_eq("st_stall_cycles", stall_n, 8);
    check_eq("st_rdv_cycles",   rdv_n, 0);
    check_eq("st_stall_cnt",    32'(stall_cnt), 11);

    // Unaligned load: flagged, no request, no stall
    clr_tally();
    drive(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("ua_err",   32'(err_unaligned), 1);
    check_eq("ua_en",    32'(mif.mem_en), 0);
    check_eq("ua_stall", 32'(pipe_stall), 0);
    idle_cyc();
    check_eq("ua_next_en",    32'(mif.mem_en), 0);
    check_eq("ua_next_err",   32'(err_unaligned), 0);
    check_eq("ua_stall_cnt",  32'(stall_cnt), 11);

    // Load that never completes; a mem_done during REQ must be ignored
    clr_tally();
    drive(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b1, 16'h1111);
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("to_wait15_stall", 32'(pipe_stall), 1);
    check_eq("to_wait15_err",   32'(err_timeout), 0);
    drive(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("to_resp_err",   32'(err_timeout), 1);
    check_eq("to_resp_valid", 32'(rd_valid), 1);
    check_eq("to_resp_data",  32'(rd_data), 32'hFFFF);
    check_eq("to_resp_stall", 32'(pipe_stall), 0);
    idle_cyc();
    check_eq("to_idle_err",   32'(err_timeout), 0);
    check_eq("to_idle_stall", 32'(pipe_stall), 0);
    check_eq("to_stall_cnt",  32'(stall_cnt), 28);

    // Back-to-back loads: second load shows up the cycle after RESP
    clr_tally();
    drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b1, 16'hA5A5);
    drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("b2b_a_data", 32'(rd_data), 32'hA5A5);
    drive(1'b1, 1'b1, 1'b0, 16'h0042, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("b2b_b_accept", 32'(pipe_stall), 1);
    drive(1'b1, 1'b1, 1'b0, 16'h0042, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("b2b_b_addr", 32'(mif.mem_addr), 32'h0042);
    drive(1'b1, 1'b1, 1'b0, 16'h0042, 16'h0, 1'b0, 1'b1, 16'h5A5A);
    drive(1'b1, 1'b1, 1'b0, 16'h0042, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("b2b_b_valid", 32'(rd_valid), 1);
    check_eq("b2b_b_data",  32'(rd_data), 32'h5A5A);
    idle_cyc();
    check_eq("b2b_en_cycles", en_n, 2);
    check_eq("b2b_rdv",       rdv_n, 2);
    check_eq("b2b_stall_cnt", 32'(stall_cnt), 34);

    // Reset while in WAIT, then a late mem_done
    clr_tally();
    drive(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, 16'h0);
    check_eq("mr_wait_stall", 32'(pipe_stall), 1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b1, 16'h7777);
    check_eq("mr_stall",     32'(pipe_stall), 0);
    check_eq("mr_en",        32'(mif.mem_en), 0);
    check_eq("mr_stall_cnt", 32'(stall_cnt), 0);
    check_eq("mr_rd_data",   32'(rd_data), 0);
    idle_cyc();
    check_eq("mr_late_valid", 32'(rd_valid), 0);
    check_eq("mr_late_data",  32'(rd_data), 0);
    check_eq("mr_late_stall", 32'(pipe_stall), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
